contador_updown_modular: RTL and testbench

- Parametrised successor to the team's N-bit down counter.
- Counts up or down over a programmable range 0..limit, with synchronous load, count enable, and wrap-around or one-shot terminal behaviour.
- Intended as the general counter/timer primitive for lab experiments: display multiplexing, timers and test sequencers.

---
 rtl/contador_pkg.sv | 12 +
 rtl/contador_next_val.sv | 27 ++
 rtl/contador_updown_modular.sv | 75 +++++++
 tb/tb_contador_updown_modular.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared types and helpers for the up/down modular counter family.
package contador_pkg;

    typedef enum logic {S_RUN, S_DONE} cnt_state_t;

    // Terminal when counting up and at/above limit, or counting down and at zero.
    function automatic logic term_cond(input logic up, input logic at_or_above_limit,
                                       input logic at_zero);
        return up ? at_or_above_limit : at_zero;
    endfunction

endpackage

// File: rtl/contador_next_val.sv
// Combinational next-value logic: step, wrap target and terminal detection.
module contador_next_val
    import contador_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] count,
    input  logic [N-1:0] limit,
    input  logic         up,
    input  logic         one_shot,
    output logic [N-1:0] next_count,
    output logic         is_terminal,
    output logic         do_wrap
);

    always_comb begin
        is_terminal = term_cond(up, count >= limit, count == '0);
        do_wrap     = is_terminal & ~one_shot;
        next_count  = count;
        if (!is_terminal) begin
            next_count = up ? count + N'(1) : count - N'(1);
        end else if (!one_shot) begin
            next_count = up ? '0 : limit;
        end
    end

endmodule

// File: rtl/contador_updown_modular.sv
// Up/down counter over 0..limit with synchronous clamped load, wrap or one-shot terminal.
module contador_updown_modular
    import contador_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic [N-1:0] limit,
    input  logic         one_shot,
    output logic [N-1:0] count,
    output logic         wrap,
    output logic         done
);

    cnt_state_t   state;
    logic [N-1:0] next_count;
    logic [N-1:0] load_clamped;
    logic         is_terminal;
    logic         do_wrap;

    contador_next_val #(.N(N)) u_next (
        .count       (count),
        .limit       (limit),
        .up          (up),
        .one_shot    (one_shot),
        .next_count  (next_count),
        .is_terminal (is_terminal),
        .do_wrap     (do_wrap)
    );

    always_comb begin
        load_clamped = (load_val > limit) ? limit : load_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
            done  <= 1'b0;
            state <= S_RUN;
        end else if (load) begin
            count <= load_clamped;
            wrap  <= 1'b0;
            done  <= 1'b0;
            state <= S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    if (en) begin
                        // next_count already holds the value on a one-shot terminal edge
                        count <= next_count;
                        wrap  <= do_wrap;
                        if (is_terminal && one_shot) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        wrap <= 1'b0;
                    end
                end
                S_DONE: begin
                    wrap <= 1'b0;
                    done <= 1'b1;
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_contador_updown_modular.sv
// Self-checking bench: directed plan steps plus random traffic against an integer model.
module tb_contador_updown_modular;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst, en, up, load, one_shot;
    logic [N-1:0] load_val, limit;
    logic [N-1:0] count;
    logic         wrap, done;

    int checks = 0;
    int errors = 0;

    int m_count;
    bit m_wrap, m_done;

    contador_updown_modular #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .one_shot (one_shot),
        .count    (count),
        .wrap     (wrap),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, int'(count), m_count);
        chk({tag, ".wrap"},  int'(wrap),  int'(m_wrap));
        chk({tag, ".done"},  int'(done),  int'(m_done));
    endtask

    task automatic model_reset();
        m_count = 0;
        m_wrap  = 0;
        m_done  = 0;
    endtask

    // Reference behaviour from the rules: clamp on load, step, wrap to the opposite end, or freeze.
    task automatic model_edge();
        int lim;
        bit at_end;
        lim = int'(limit);
        if (load) begin
            m_count = (int'(load_val) > lim) ? lim : int'(load_val);
            m_wrap  = 0;
            m_done  = 0;
        end else if (m_done || !en) begin
            m_wrap = 0;
        end else begin
            at_end = up ? (m_count >= lim) : (m_count == 0);
            if (!at_end) begin
                m_count = up ? m_count + 1 : m_count - 1;
                m_wrap  = 0;
            end else if (one_shot) begin
                m_done = 1;
                m_wrap = 0;
            end else begin
                m_count = up ? 0 : lim;
                m_wrap  = 1;
            end
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        int wraps;
        bit found;
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; one_shot = 1'b0;
        load_val = '0; limit = 8'd255;
        #1;
        model_reset();
        chk_all("reset");
        #10;
        rst = 1'b0;

        // 1: count to 37, then async reset between edges
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 37; i++) tick("t1.run");
        chk("t1.at37", int'(count), 37);
        async_reset("t1.async");
        tick("t1.resume");
        chk("t1.first", int'(count), 1);

        // 2: full-range down wrap
        en = 1'b0;
        async_reset("t2.rst");
        up = 1'b0; limit = 8'd255; one_shot = 1'b0; en = 1'b1;
        wraps = 0;
        for (int i = 1; i <= 512; i++) begin
            tick("t2.run");
            if (wrap) wraps++;
            if (i == 1) begin
                chk("t2.first", int'(count), 255);
                chk("t2.firstwrap", int'(wrap), 1);
            end
            if (i == 256) chk("t2.edge256", int'(count), 0);
        end
        chk("t2.wraps", wraps, 2);

        // 3: modulo-10 up, then reverse at 4
        en = 1'b0;
        async_reset("t3.rst");
        limit = 8'd9; up = 1'b1; en = 1'b1;
        wraps = 0;
        for (int i = 0; i < 25; i++) begin
            tick("t3.run");
            if (wrap) begin
                wraps++;
                chk("t3.wrapzero", int'(count), 0);
            end
        end
        chk("t3.wraps", wraps, 2);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (count == 8'd4) found = 1;
            else tick("t3.seek");
        end
        chk("t3.found4", int'(found), 1);
        up = 1'b0;
        tick("t3.dn1");
        chk("t3.three", int'(count), 3);
        tick("t3.dn2");
        chk("t3.two", int'(count), 2);

        // 4: one-shot down from 5
        load_val = 8'd5; load = 1'b1; one_shot = 1'b1; up = 1'b0;
        tick("t4.load");
        load = 1'b0;
        for (int i = 0; i < 5; i++) tick("t4.down");
        chk("t4.zero", int'(count), 0);
        tick("t4.term");
        chk("t4.done", int'(done), 1);
        for (int i = 0; i < 20; i++) begin
            tick("t4.hold");
            chk("t4.nowrap", int'(wrap), 0);
        end
        load_val = 8'd3; load = 1'b1;
        tick("t4.reload");
        chk("t4.reload3", int'(count), 3);
        chk("t4.cleared", int'(done), 0);
        load = 1'b0;
        tick("t4.resume");
        chk("t4.two", int'(count), 2);

        // 5: load clamp beats enable
        limit = 8'd9; load_val = 8'd200; load = 1'b1; en = 1'b1; one_shot = 1'b0;
        tick("t5.clamp");
        chk("t5.nine", int'(count), 9);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) tick("t5.hold");
        chk("t5.held", int'(count), 9);

        // 6: degenerate range
        limit = 8'd0; load_val = 8'd0; load = 1'b1;
        tick("t6.load");
        load = 1'b0; en = 1'b1; one_shot = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick("t6.wrap");
            chk("t6.pulse", int'(wrap), 1);
        end
        one_shot = 1'b1;
        tick("t6.oneshot");
        chk("t6.done", int'(done), 1);

        // Random traffic, with occasional mid-cycle resets
        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(0, 9) < 8);
            up       = $urandom_range(0, 1) == 1;
            load     = ($urandom_range(0, 19) == 0);
            one_shot = ($urandom_range(0, 3) == 0);
            load_val = N'($urandom);
            if ($urandom_range(0, 15) == 0)
                limit = ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 12)) : N'($urandom);
            tick("rand");
            if ($urandom_range(0, 99) == 0) async_reset("rand.rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
